clkmux_n: RTL and testbench
===========================

CLKMUX_N -- requirements
Module: clkmux_n

Interface
REQ-001 Parameter N, default 4: number of source clocks; legal range 2..8.
REQ-002 Parameter SW, default 2: select width; SHALL equal ceil(log2(N)).
REQ-003 Parameter SYNC, default 2: synchroniser stages per channel; legal range 2..4.
REQ-004 Parameter INIT, default 0: channel enabled out of reset; legal range 0..N-1.
REQ-005 clk  input  N  source clocks, mutually asynchronous; clock clk, bit i drives channel i only.
REQ-006 rstb  input  1  reset rstb, asynchronous, active-low; shared by all channels.
REQ-007 sel  input  SW  requested channel index; may change asynchronously to every clk[i].
REQ-008 vld  output  N  per-channel enable; bit i is registered in the clk[i] domain; at most one bit set.
REQ-009 lck  output  1  muxed clock, equal to OR over i of (vld[i] AND clk[i]).
REQ-010 cur  output  SW  binary index of the set vld bit; 0 when vld is all zero.
REQ-011 idle  output  1  high when vld is all zero, i.e. a switch is in progress or sel is out of range.

Function
REQ-012 Each channel i SHALL own a SYNC-deep shift register s_i clocked on posedge clk[i] and a final enable flop clocked on negedge clk[i] driving vld[i].
REQ-013 s_i stage-0 input SHALL be (sel == i) AND NOT(OR of vld[j] for all j != i).
REQ-014 vld[i] SHALL load the last s_i stage on each falling edge of clk[i], so vld[i] only changes while clk[i] is low.
REQ-015 Switch-off latency, channel i: vld[i] falls on the first negedge clk[i] after SYNC posedges of clk[i] that sample sel != i.
REQ-016 Switch-on latency, channel j: vld[j] rises on the first negedge clk[j] after SYNC posedges of clk[j] that sample sel == j with all other vld low. The off-going channel is therefore fully low before channel j rises (break-before-make).
REQ-017 Between the fall of the old vld and the rise of the new vld, lck SHALL be held low with no pulse shorter than the low or high phase of either source.
REQ-018 sel >= N SHALL disable all channels: lck stays low and idle stays high until a legal sel is presented.
REQ-019 If sel returns to the active channel i before vld[i] falls, vld[i] SHALL stay high; any partial pulse in s_i SHALL be absorbed without lck disturbance.
REQ-020 If sel changes again during a switch, the mux SHALL end at the most recent legal sel; no two vld bits are ever simultaneously high.
REQ-021 A stopped clk[i] with vld[i] high SHALL freeze the mux; this is documented behaviour, not a fault to be detected.
REQ-022 cur and idle are combinational from vld and may glitch during a switch; consumers SHALL sample them only when stable.

Reset
REQ-023 rstb low SHALL asynchronously set s_INIT and vld[INIT] to all ones, clear every other s_i and vld[i], and run lck from clk[INIT].
REQ-024 Each channel SHALL have its own SYNC-stage reset synchroniser: assertion asynchronous, deassertion synchronous to posedge clk[i].
REQ-025 After release with sel == INIT, no vld bit SHALL change.
REQ-026 rstb asserted mid-switch SHALL return the mux to the INIT state immediately, irrespective of clock activity.

Verification (N=4, SYNC=2, INIT=0; clk0 10 ns, clk1 13 ns, clk2 7 ns, clk3 29 ns)
REQ-027 Reset with sel=0, then release -> vld=4'b0001, cur=0, idle=0, lck follows clk0, no change for 1000 ns.
REQ-028 sel 0->2 -> vld[0] falls at the 2nd clk0 posedge plus the next negedge; vld[2] rises at the 2nd clk2 posedge plus the next negedge after that; lck low in between; minimum lck high and low width >= 3.5 ns.
REQ-029 sel 2->1, then 1->3 after 5 ns -> vld settles at 4'b1000; vld[1] never rises, or rises and falls cleanly; $onehot0(vld) holds throughout.
REQ-030 sel 0->2->0 within 5 ns -> vld[0] stays high, vld[2] never rises, lck is uninterrupted clk0.
REQ-031 sel=3'b... out of range: use N=3, sel=3 -> vld=0, idle=1, lck low; then sel=1 -> vld=3'b010.
REQ-032 rstb pulsed low mid-switch 2->1 -> vld=4'b0001 asynchronously within the reset pulse.

Source files
------------

// File: rtl/clkmux_n.sv
// Glitch-free N-way clock multiplexer: per-channel synchronised enables with
// break-before-make handover between mutually asynchronous source clocks.
module clkmux_n #(
   parameter int N    = 4,
   parameter int SW   = 2,
   parameter int SYNC = 2,
   parameter int INIT = 0
) (
   input  logic [N-1:0]  clk,
   input  logic          rstb,
   input  logic [SW-1:0] sel,
   output logic [N-1:0]  vld,
   output logic          lck,
   output logic [SW-1:0] cur,
   output logic          idle
);

   for (genvar i = 0; i < N; i++) begin : g_ch
      localparam logic         RST_ON = (i == INIT);
      localparam logic [N-1:0] OTHERS = ~(N'(1) << i);

      logic [SYNC-1:0] r_rst_sync;
      logic            w_rst_n;
      logic            w_req;
      logic [SYNC-1:0] r_s;
      logic            r_vld;

      // NOTE: reset asserts at once but is released on this channel's own clock,
      // so every channel leaves reset cleanly even while the others run.
      always_ff @(posedge clk[i] or negedge rstb) begin
         if (!rstb) r_rst_sync <= '0;
         else       r_rst_sync <= {r_rst_sync[SYNC-2:0], 1'b1};
      end

      assign w_rst_n = r_rst_sync[SYNC-1];
      assign w_req   = (sel == SW'(i)) && !(|(vld & OTHERS));

      always_ff @(posedge clk[i] or negedge w_rst_n) begin
         if (!w_rst_n) r_s <= {SYNC{RST_ON}};
         else          r_s <= {r_s[SYNC-2:0], w_req};
      end

      // NOTE: the enable moves on the falling edge, only once every stage agrees;
      // a lone stray sample is absorbed and vld[i] never changes with clk[i] high.
      always_ff @(negedge clk[i] or negedge w_rst_n) begin
         if (!w_rst_n)   r_vld <= RST_ON;
         else if (r_vld) r_vld <= |r_s;
         else            r_vld <= &r_s;
      end

      assign vld[i] = r_vld;
   end

   assign lck  = |(vld & clk);
   assign idle = ~|vld;

   // NOTE: default assigned first so the encoder never infers a latch.
   always_comb begin
      cur = '0;
      for (int i = 0; i < N; i++) begin
         if (vld[i]) cur = SW'(i);
      end
   end

endmodule

// File: tb/tb_clkmux_n.sv
// Self-checking bench for clkmux_n: directed table, hand-written corner cases
// and randomised switches against a timing model built from the clock periods.
`timescale 1ns/1ps
module tb_clkmux_n;

   localparam int SYNC = 2;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] vld;
      logic [1:0] cur;
      logic       idle;
   } vec_t;

   logic clk0 = 1'b0, clk1 = 1'b0, clk2 = 1'b0, clk3 = 1'b0;
   logic [3:0] clk;
   logic       rstb = 1'b1;
   logic [1:0] sel  = 2'd0;
   logic [3:0] vld;
   logic       lck;
   logic [1:0] cur;
   logic       idle;
   logic [1:0] sel3 = 2'd0;
   logic [2:0] vld3;
   logic       lck3;
   logic [1:0] cur3;
   logic       idle3;

   real per [4] = '{10.0, 13.0, 7.0, 29.0};

   always #5.0  clk0 = ~clk0;
   always #6.5  clk1 = ~clk1;
   always #3.5  clk2 = ~clk2;
   always #14.5 clk3 = ~clk3;
   assign clk = {clk3, clk2, clk1, clk0};

   clkmux_n #(.N(4), .SW(2), .SYNC(SYNC), .INIT(0)) dut (
      .clk(clk), .rstb(rstb), .sel(sel), .vld(vld), .lck(lck), .cur(cur), .idle(idle)
   );

   clkmux_n #(.N(3), .SW(2), .SYNC(SYNC), .INIT(0)) dut3 (
      .clk(clk[2:0]), .rstb(rstb), .sel(sel3), .vld(vld3), .lck(lck3), .cur(cur3), .idle(idle3)
   );

   int  n_tests = 0;
   int  n_fail  = 0;
   bit  armed   = 1'b0;
   int  n_rise [4] = '{0, 0, 0, 0};
   int  n_fall [4] = '{0, 0, 0, 0};
   real t_rise [4] = '{0.0, 0.0, 0.0, 0.0};
   real t_fall [4] = '{0.0, 0.0, 0.0, 0.0};
   logic [3:0] vld_prev = 4'b0000;
   int  onehot_viol = 0;
   int  phase_viol  = 0;
   int  idle_viol   = 0;
   int  n_rst       = 0;
   real lck_last    = 0.0;
   bit  lck_last_ok = 1'b0;
   int  lck_epoch   = 0;
   real min_hi      = 1.0e9;
   real min_lo      = 1.0e9;
   int  m_ch        = 0;

   // Edge recorder and continuous safety monitors on the 4-channel instance.
   always @(vld) begin
      for (int i = 0; i < 4; i++) begin
         if (vld[i] !== vld_prev[i]) begin
            if (vld[i]) begin n_rise[i]++; t_rise[i] = $realtime; end
            else        begin n_fall[i]++; t_fall[i] = $realtime; end
            if (armed && rstb && clk[i]) phase_viol++;
         end
      end
      if (armed && !$onehot0(vld)) onehot_viol++;
      vld_prev = vld;
   end

   always @(lck or vld) begin
      if (armed && rstb && vld == 4'b0000 && lck) idle_viol++;
   end

   always @(negedge rstb) n_rst++;

   always @(lck) begin
      if (armed && rstb && lck_last_ok && lck_epoch == n_rst) begin
         if (lck) min_lo = ($realtime - lck_last < min_lo) ? $realtime - lck_last : min_lo;
         else     min_hi = ($realtime - lck_last < min_hi) ? $realtime - lck_last : min_hi;
      end
      lck_last    = $realtime;
      lck_last_ok = armed && rstb;
      lck_epoch   = n_rst;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0.2f ns", name, act, exp, $realtime);
      end
   endtask

   task automatic check_time(input string name, input real act, input real e1, input real e2);
      real d1, d2;
      d1 = (act > e1) ? act - e1 : e1 - act;
      d2 = (act > e2) ? act - e2 : e2 - act;
      n_tests++;
      if (!(d1 < 0.01 || d2 < 0.01)) begin
         n_fail++;
         $display("FAIL %s: edge at %0.3f ns expected %0.3f ns (or %0.3f ns)", name, act, e1, e2);
      end
   endtask

   task automatic check_min(input string name, input real act, input real lim);
      n_tests++;
      if (act < lim - 0.001) begin
         n_fail++;
         $display("FAIL %s: got %0.3f ns required at least %0.3f ns", name, act, lim);
      end
   endtask

   // Reference timing: the n-th rising edge of clk[ch] after t (strictly, or at-or-after
   // when incl is set), then the following falling edge.
   function automatic real neg_after(input int ch, input real t, input int n, input bit incl);
      real h, tp;
      h  = per[ch] / 2.0;
      tp = h;
      while (incl ? (tp < t - 0.001) : (tp <= t + 0.001)) tp += per[ch];
      tp += (n - 1) * per[ch];
      return tp + h;
   endfunction

   function automatic int sum_edges();
      int s;
      s = 0;
      for (int i = 0; i < 4; i++) s += n_rise[i] + n_fall[i];
      return s;
   endfunction

   task automatic do_switch(input logic [1:0] b, input logic [3:0] e_vld, input logic [1:0] e_cur,
                            input logic e_idle, input string tag);
      real ts, tf, tr_s, tr_i;
      int  rise0, edges0;
      rise0  = n_rise[b];
      edges0 = sum_edges();
      ts     = $realtime;
      tf     = neg_after(m_ch, ts, SYNC, 1'b0);
      tr_s   = neg_after(int'(b), tf, SYNC, 1'b0);
      tr_i   = neg_after(int'(b), tf, SYNC, 1'b1);
      sel    = b;
      #300;
      check({tag, "_vld"},  vld,  e_vld);
      check({tag, "_cur"},  cur,  e_cur);
      check({tag, "_idle"}, idle, e_idle);
      if (int'(b) != m_ch) begin
         check_time({tag, "_fall_time"}, t_fall[m_ch], tf, tf);
         check_time({tag, "_rise_time"}, t_rise[b], tr_s, tr_i);
         check({tag, "_rise_count"}, n_rise[b] - rise0, 1);
      end else begin
         check({tag, "_no_edges"}, sum_edges() - edges0, 0);
      end
      m_ch = int'(b);
   endtask

   initial begin
      vec_t tbl [6];
      int   mism, edges0, f0, r2, highs, k;

      tbl[0] = '{sel: 2'd2, vld: 4'b0100, cur: 2'd2, idle: 1'b0};
      tbl[1] = '{sel: 2'd1, vld: 4'b0010, cur: 2'd1, idle: 1'b0};
      tbl[2] = '{sel: 2'd3, vld: 4'b1000, cur: 2'd3, idle: 1'b0};
      tbl[3] = '{sel: 2'd0, vld: 4'b0001, cur: 2'd0, idle: 1'b0};
      tbl[4] = '{sel: 2'd0, vld: 4'b0001, cur: 2'd0, idle: 1'b0};
      tbl[5] = '{sel: 2'd2, vld: 4'b0100, cur: 2'd2, idle: 1'b0};

      // Reset state and quiet release.
      #1 rstb = 1'b0;
      #1 armed = 1'b1;
      #48.25;
      check("rst_vld", vld, 4'b0001);
      check("rst_cur", cur, 2'd0);
      check("rst_idle", idle, 1'b0);
      rstb   = 1'b1;
      edges0 = sum_edges();
      mism   = 0;
      for (int i = 0; i < 1000; i++) begin
         #1;
         if (lck !== clk0) mism++;
      end
      check("rel_vld", vld, 4'b0001);
      check("rel_cur", cur, 2'd0);
      check("rel_idle", idle, 1'b0);
      check("rel_no_edges", sum_edges() - edges0, 0);
      check("rel_lck_is_clk0", mism, 0);

      // Short excursion to channel 2 that one clk0 rising edge samples.
      @(posedge clk0);
      #8.25;
      f0 = n_fall[0];
      r2 = n_rise[2];
      sel = 2'd2;
      #5;
      sel  = 2'd0;
      mism = 0;
      for (int i = 0; i < 150; i++) begin
         #1;
         if (lck !== clk0) mism++;
      end
      check("glitch_vld0_kept", n_fall[0] - f0, 0);
      check("glitch_vld2_quiet", n_rise[2] - r2, 0);
      check("glitch_lck_is_clk0", mism, 0);
      check("glitch_vld", vld, 4'b0001);

      for (int i = 0; i < 6; i++) begin
         do_switch(tbl[i].sel, tbl[i].vld, tbl[i].cur, tbl[i].idle, $sformatf("tbl%0d", i));
         #($urandom_range(0, 20));
      end

      // Retarget during a switch: 2 -> 1, then 1 -> 3 five ns later.
      sel = 2'd1;
      #5;
      sel = 2'd3;
      #300;
      check("retarget_vld", vld, 4'b1000);
      check("retarget_cur", cur, 2'd3);
      m_ch = 3;

      // Reset asserted in the gap of a 2 -> 1 switch.
      do_switch(2'd2, 4'b0100, 2'd2, 1'b0, "pre_rst");
      sel = 2'd1;
      k = 0;
      while (vld[2] !== 1'b0 && k < 200) begin #1; k++; end
      check("rst_mid_vld2_fell", vld[2], 1'b0);
      #2 rstb = 1'b0;
      #1;
      check("rst_mid_vld", vld, 4'b0001);
      check("rst_mid_cur", cur, 2'd0);
      check("rst_mid_idle", idle, 1'b0);
      sel = 2'd0;
      #20 rstb = 1'b1;
      #300;
      check("rst_mid_after", vld, 4'b0001);
      m_ch = 0;

      // Out-of-range select on the 3-channel instance.
      sel3 = 2'd3;
      #300;
      check("oor_vld", vld3, 3'b000);
      check("oor_idle", idle3, 1'b1);
      check("oor_cur", cur3, 2'd0);
      highs = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (lck3 !== 1'b0) highs++;
      end
      check("oor_lck_low", highs, 0);
      sel3 = 2'd1;
      #300;
      check("oor_recover_vld", vld3, 3'b010);
      check("oor_recover_cur", cur3, 2'd1);
      check("oor_recover_idle", idle3, 1'b0);

      for (int i = 0; i < 24; i++) begin
         logic [1:0] b;
         b = 2'($urandom_range(0, 3));
         #($urandom_range(0, 40));
         do_switch(b, 4'(1) << b, b, 1'b0, $sformatf("rnd%0d", i));
      end

      check("onehot0_always", onehot_viol, 0);
      check("vld_moves_clk_low", phase_viol, 0);
      check("lck_low_when_idle", idle_viol, 0);
      check_min("lck_min_high", min_hi, 3.5);
      check_min("lck_min_low", min_lo, 3.5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
